// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the serial subtractor and the adder/subtractor benches:
// FSM state encoding and the default datapath width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bi, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = x - y over WIDTH cycles, LSB first, with a
// start/busy/done handshake and registered results.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor_bit u_fs (
    .a  (x_q[0]),
    .b  (y_q[0]),
    .bi (borrow_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    acc_d        = acc_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    count_d      = count_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          x_d      = x;
          y_d      = y;
          acc_d    = '0;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = StShift;
        end else begin
          state_d  = StIdle;
        end
      end
      StShift: begin
        // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        acc_d    = {d_bit, acc_q[WIDTH-1:1]};
        x_d      = x_q >> 1;
        y_d      = y_q >> 1;
        borrow_d = bo_bit;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          diff_d       = {d_bit, acc_q[WIDTH-1:1]};
          borrow_out_d = bo_bit;
          state_d      = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      acc_q        <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_q        <= acc_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      count_q      <= count_d;
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=5): a result scoreboard is
// filled when operands are launched and drained when done pulses.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] x;
  logic [4:0] y;
  logic       busy;
  logic       done;
  logic [4:0] diff;
  logic       borrow_out;

  int tests = 0;
  int fails = 0;
  logic [5:0] sb[$];  // {borrow, diff}

  serial_subtractor #(
    .WIDTH (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [4:0] a, input logic [4:0] b, input bit push,
                          input logic [5:0] exp);
    start = 1'b1;
    x     = a;
    y     = b;
    if (push) sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    x     = 5'($urandom);
    y     = 5'($urandom);
  endtask

  // cyc counts cycles from the start cycle to the done cycle.
  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        cyc = i + 2;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    #3;
    tests++;
    if ({busy, done, borrow_out, diff} !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b borrow=%b diff=%b, expected all 0",
               busy, done, borrow_out, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [4:0] va[4] = '{5'b00101, 5'b00011, 5'b11111, 5'b00000};
    logic [4:0] vb[4] = '{5'b00011, 5'b00101, 5'b11111, 5'b00001};
    logic [5:0] ve[4] = '{6'b0_00010, 6'b1_11110, 6'b0_00000, 6'b1_11111};
    int cyc;
    bit ok;
    logic [5:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i], 1'b1, ve[i]);
      wait_done(cyc, ok);
      exp = sb.pop_front();
      tests++;
      if (!ok || cyc != 6) begin
        fails++;
        $display("FAIL basic_latency[%0d]: got %0d cycles (seen=%0b), expected 6", i, cyc, ok);
      end
      tests++;
      if ({borrow_out, diff} !== exp) begin
        fails++;
        $display("FAIL basic_result[%0d]: got borrow=%b diff=%b, expected borrow=%b diff=%b",
                 i, borrow_out, diff, exp[5], exp[4:0]);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || {borrow_out, diff} !== exp) begin
        fails++;
        $display("FAIL basic_hold[%0d]: got done=%b borrow=%b diff=%b, expected done=0 %b %b",
                 i, done, borrow_out, diff, exp[5], exp[4:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit ok;
    int extra;
    logic [5:0] exp;
    logic [4:0] prev;
    prev = diff;
    start_op(5'b01010, 5'b01111, 1'b1, 6'b1_11011);
    @(posedge clk); #1;
    start = 1'b1;
    x     = 5'b10001;
    y     = 5'b10011;
    tests++;
    if (busy !== 1'b1 || diff !== prev) begin
      fails++;
      $display("FAIL ignored_busy: got busy=%b diff=%b, expected busy=1 diff=%b",
               busy, diff, prev);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, ok);
    exp = sb.pop_front();
    tests++;
    if (!ok || {borrow_out, diff} !== exp) begin
      fails++;
      $display("FAIL ignored_result: got borrow=%b diff=%b (seen=%0b), expected %b %b",
               borrow_out, diff, ok, exp[5], exp[4:0]);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ignored_no_second_op: got %0d extra done pulses, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    logic [5:0] exp;
    start_op(5'b10110, 5'b00111, 1'b1, 6'b0_01111);
    wait_done(cyc, ok);
    exp = sb.pop_front();
    tests++;
    if (!ok || {borrow_out, diff} !== exp) begin
      fails++;
      $display("FAIL b2b_first: got borrow=%b diff=%b (seen=%0b), expected %b %b",
               borrow_out, diff, ok, exp[5], exp[4:0]);
    end
    start_op(5'b00100, 5'b01001, 1'b1, 6'b1_11011);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b, expected 1", busy);
    end
    wait_done(cyc, ok);
    exp = sb.pop_front();
    tests++;
    if (!ok || cyc != 6 || {borrow_out, diff} !== exp) begin
      fails++;
      $display("FAIL b2b_second: got borrow=%b diff=%b cyc=%0d, expected %b %b cyc=6",
               borrow_out, diff, cyc, exp[5], exp[4:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bit ok;
    int pulses;
    logic [5:0] exp;
    start_op(5'b10001, 5'b00011, 1'b0, 6'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, borrow_out, diff} !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_op: got busy=%b done=%b borrow=%b diff=%b, expected all 0",
               busy, done, borrow_out, diff);
    end
    #2;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d done pulses, expected 0", pulses);
    end
    start_op(5'b01100, 5'b00100, 1'b1, 6'b0_01000);
    wait_done(cyc, ok);
    exp = sb.pop_front();
    tests++;
    if (!ok || cyc != 6 || {borrow_out, diff} !== exp) begin
      fails++;
      $display("FAIL reset_recover: got borrow=%b diff=%b cyc=%0d, expected %b %b cyc=6",
               borrow_out, diff, cyc, exp[5], exp[4:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    int cyc;
    bit ok;
    int bad_res;
    int bad_add;
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] exp;
    bad_res = 0;
    bad_add = 0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        a = 5'(i);
        b = 5'(j);
        start_op(a, b, 1'b1, {i < j, 5'(i - j)});
        wait_done(cyc, ok);
        exp = sb.pop_front();
        if (!ok || {borrow_out, diff} !== exp) begin
          bad_res++;
          if (bad_res <= 4)
            $display("FAIL exhaustive %0d-%0d: got borrow=%b diff=%b, expected %b %b",
                     i, j, borrow_out, diff, exp[5], exp[4:0]);
        end
        if (5'(diff + b) !== a) begin
          bad_add++;
          if (bad_add <= 4)
            $display("FAIL adder_xcheck %0d-%0d: got diff+y=%0d, expected %0d",
                     i, j, 5'(diff + b), a);
        end
        @(posedge clk); #1;
      end
    end
    tests++;
    if (bad_res != 0) begin
      fails++;
      $display("FAIL exhaustive_total: got %0d bad results, expected 0", bad_res);
    end
    tests++;
    if (bad_add != 0) begin
      fails++;
      $display("FAIL adder_xcheck_total: got %0d bad sums, expected 0", bad_add);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
